// File: rtl/bp_pkg_cp4.sv
// ---------------------------------------------------------------------------
// bp_pkg_cp4 : shared branch-predictor types, defaults and index helper. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bp_pkg_cp4;

  localparam int CNT_WIDTH = 2;
  localparam int IDX_BITS  = 5;
  localparam logic [CNT_WIDTH-1:0] INIT_VAL = {1'b0, {CNT_WIDTH-1{1'b1}}};

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bht_state_t;

  // Word index of a PC, masked to the given index width.
  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int unsigned bits);
    return (pc >> 2) & ((32'd1 << bits) - 32'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_updn_cp4.sv
// ---------------------------------------------------------------------------
// sat_updn_cp4 : saturating up/down counter step (combinational). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sat_updn_cp4 #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             up_i,
  input  logic             dn_i,
  output logic [WIDTH-1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (up_i && !dn_i && (cnt_i != '1)) begin
      cnt_o = cnt_i + WIDTH'(1);
    end else if (dn_i && !up_i && (cnt_i != '0)) begin
      cnt_o = cnt_i - WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/bht_ctrl_cp4.sv
// ---------------------------------------------------------------------------
// bht_ctrl_cp4 : direct-mapped BHT with init walk and 1-stage update RMW. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bht_ctrl_cp4 #(
  parameter int                      IDX_BITS  = bp_pkg_cp4::IDX_BITS,
  parameter int                      CNT_WIDTH = bp_pkg_cp4::CNT_WIDTH,
  parameter logic [CNT_WIDTH-1:0]    INIT_VAL  = {1'b0, {CNT_WIDTH-1{1'b1}}}
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  output logic        ready
);

  import bp_pkg_cp4::*;

  localparam int DEPTH = 1 << IDX_BITS;

  logic [CNT_WIDTH-1:0] mem_q [DEPTH];

  bht_state_t           state_q;
  logic [IDX_BITS-1:0]  init_idx_q;
  logic                 ready_q;
  logic                 pred_valid_q;
  logic                 pred_taken_q;
  logic                 u1_valid_q;
  logic [IDX_BITS-1:0]  u1_idx_q;
  logic                 u1_taken_q;

  logic [IDX_BITS-1:0]  lk_idx;
  logic [IDX_BITS-1:0]  up_idx;
  logic [CNT_WIDTH-1:0] u1_cnt;
  logic [CNT_WIDTH-1:0] u1_cnt_d;
  logic                 in_run;

  assign lk_idx = IDX_BITS'(pc_index(lookup_pc, IDX_BITS));
  assign up_idx = IDX_BITS'(pc_index(upd_pc, IDX_BITS));
  assign u1_cnt = mem_q[u1_idx_q];
  assign in_run = (state_q == ST_RUN);

  sat_updn_cp4 #(
    .WIDTH (CNT_WIDTH)
  ) u_sat (
    .cnt_i (u1_cnt),
    .up_i  (u1_taken_q),
    .dn_i  (!u1_taken_q),
    .cnt_o (u1_cnt_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_INIT;
      init_idx_q   <= '0;
      ready_q      <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      u1_valid_q   <= 1'b0;
      u1_idx_q     <= '0;
      u1_taken_q   <= 1'b0;
    end else begin
      pred_valid_q <= lookup_valid;
      // Array read here sees the pre-write value of any same-edge U1 write.
      pred_taken_q <= lookup_valid && in_run && mem_q[lk_idx][CNT_WIDTH-1];
      u1_valid_q   <= upd_valid && in_run && !clear;
      u1_idx_q     <= up_idx;
      u1_taken_q   <= upd_taken;
      if (clear) begin
        state_q    <= ST_INIT;
        init_idx_q <= '0;
        ready_q    <= 1'b0;
      end else if (state_q == ST_INIT) begin
        init_idx_q <= init_idx_q + IDX_BITS'(1);
        if (init_idx_q == '1) begin
          state_q <= ST_RUN;
          ready_q <= 1'b1;
        end
      end
    end
  end

  // A clear on the same edge as a pending write squashes that write.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[init_idx_q] <= INIT_VAL;
    end else if (u1_valid_q && !clear) begin
      mem_q[u1_idx_q] <= u1_cnt_d;
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign ready      = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_bht_ctrl_cp4.sv
// ---------------------------------------------------------------------------
// tb_bht_ctrl_cp4 : directed + random bench with a behavioural table model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bht_ctrl_cp4;

  localparam int ENTRIES = 32;
  localparam int CMAX    = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        pred_valid;
  logic        pred_taken;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic        ready;

  bht_ctrl_cp4 dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .lookup_valid (lookup_valid),
    .lookup_pc    (lookup_pc),
    .pred_valid   (pred_valid),
    .pred_taken   (pred_taken),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .ready        (ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: counter values as integers, init as a countdown.
  int m_tab [ENTRIES];
  bit m_run       = 1'b0;
  int m_init_left = ENTRIES;
  bit m_pend_v    = 1'b0;
  int m_pend_i    = 0;
  bit m_pend_t    = 1'b0;
  bit exp_pv      = 1'b0;
  bit exp_pt      = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  task automatic cycle();
    bit nv;
    int ni;
    bit nt;
    @(posedge clk);
    if (rst) begin
      m_run = 1'b0; m_init_left = ENTRIES; m_pend_v = 1'b0;
      exp_pv = 1'b0; exp_pt = 1'b0;
    end else begin
      exp_pv = lookup_valid;
      exp_pt = lookup_valid && m_run && (m_tab[idx_of(lookup_pc)] >= 2);
      if (m_pend_v && !clear) begin
        if (m_pend_t && m_tab[m_pend_i] < CMAX) m_tab[m_pend_i]++;
        if (!m_pend_t && m_tab[m_pend_i] > 0)   m_tab[m_pend_i]--;
      end
      nv = upd_valid && m_run && !clear;
      ni = idx_of(upd_pc);
      nt = upd_taken;
      m_pend_v = nv; m_pend_i = ni; m_pend_t = nt;
      if (clear) begin
        m_run = 1'b0; m_init_left = ENTRIES;
      end else if (!m_run) begin
        m_init_left--;
        if (m_init_left == 0) begin
          m_run = 1'b1;
          foreach (m_tab[k]) m_tab[k] = 1;
        end
      end
    end
    #1;
    check("pred_valid", pred_valid, exp_pv);
    check("pred_taken", pred_taken, exp_pt);
    check("ready", ready, m_run);
  endtask

  task automatic drv(input bit lv, input logic [31:0] lpc, input bit uv,
                     input logic [31:0] upc, input bit ut, input bit clr);
    lookup_valid = lv; lookup_pc = lpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; clear = clr;
    cycle();
  endtask

  task automatic idle();
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic init_walk(input string tag);
    for (int i = 0; i < ENTRIES; i++) begin
      drv(1'b1, $urandom, 1'b1, $urandom, 1'b1, 1'b0);
      check(tag, ready, (i == ENTRIES - 1));
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check("reset_outputs", {29'd0, ready, pred_valid, pred_taken}, 32'd0);
    repeat (3) cycle();
    rst = 1'b0;
    init_walk("init_ready");

    drv(1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b0);
    check("post_init_lookup", pred_taken, 1'b0);

    // Training 0x40: 01 -> 10 -> 11
    drv(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0);
    drv(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0);
    idle();
    drv(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    check("train_taken", pred_taken, 1'b1);
    drv(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0);
    drv(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b0);
    drv(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b0);
    idle();
    drv(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    check("sat_high_then_nt", pred_taken, 1'b0);

    // Saturate low on 0x80, then alias from 0x100
    repeat (4) drv(1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 1'b0);
    drv(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 1'b0);
    idle();
    drv(1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0);
    check("alias_low", pred_taken, 1'b0);
    drv(1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 1'b0);
    idle();
    drv(1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0);
    check("alias_rise", pred_taken, 1'b1);

    // Read-before-write collision on 0x44
    drv(1'b0, 32'h0, 1'b1, 32'h44, 1'b1, 1'b0);
    drv(1'b1, 32'h44, 1'b0, 32'h0, 1'b0, 1'b0);
    check("collision_old", pred_taken, 1'b0);
    drv(1'b1, 32'h44, 1'b0, 32'h0, 1'b0, 1'b0);
    check("collision_new", pred_taken, 1'b1);

    // Clear with a pending update to 0x40 (01 -> 11 first)
    drv(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0);
    drv(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0);
    idle();
    drv(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 1'b0);
    check("pre_clear_taken", pred_taken, 1'b1);
    drv(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b1);
    check("clear_ready_drop", ready, 1'b0);
    init_walk("clear_ready");
    drv(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    check("after_clear", pred_taken, 1'b0);

    // Async reset partway through the walk
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    repeat (10) drv(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    check("midinit_pv_before", pred_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("async_rst_outputs", {29'd0, ready, pred_valid, pred_taken}, 32'd0);
    repeat (3) cycle();
    rst = 1'b0;
    init_walk("reinit_ready");

    // Randomised traffic on a handful of aliasing PCs
    for (int c = 0; c < 3000; c++) begin
      drv($urandom_range(0, 1), $urandom & 32'h0000_01FC,
          $urandom_range(0, 3) != 0, $urandom & 32'h0000_01FC,
          $urandom_range(0, 1), $urandom_range(0, 299) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bht_ctrl_cp4.md
# bht_ctrl_cp4

Branch history table controller for the cp4 core. It owns a direct-mapped array of saturating direction counters and serves one prediction lookup per cycle from fetch. It accepts one resolved-branch update per cycle from execute, applying it as a registered read-modify-write through `sat_updn_cp4`. After reset, or on a `clear` request, it sequences a table-wide initialisation before it accepts traffic.

## Interface

**Parameters**
- `IDX_BITS`, default 5: index width; table depth is 2^IDX_BITS entries.
- `CNT_WIDTH`, default 2: counter width.
- `INIT_VAL`, default {1'b0, {CNT_WIDTH-1{1'b1}}}: initialisation value, weakly not-taken (2'b01 at defaults).

**Ports**
- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `clear` in 1: synchronous request to re-initialise the table.
- `lookup_valid` in 1: fetch requests a prediction.
- `lookup_pc` in 32: PC of the fetched instruction.
- `pred_valid` out 1: prediction response valid.
- `pred_taken` out 1: predicted direction.
- `upd_valid` in 1: execute reports a resolved conditional branch.
- `upd_pc` in 32: PC of that branch.
- `upd_taken` in 1: actual direction.
- `ready` out 1: table initialised; lookups and updates are honoured.

## Operation

- **Index:** `pc[IDX_BITS+1:2]`. No tags, so aliasing is permitted.
- **Prediction:** the counter MSB (1 = taken).
- **FSM states:**
  - `INIT`
    - Counter `init_idx` walks from 0 to 2^IDX_BITS-1.
    - Writes `INIT_VAL` to one entry per cycle.
    - After writing the last entry, moves to `RUN`.
  - `RUN`
    - Normal operation.
    - `clear` in `RUN` moves to `INIT` with `init_idx` = 0.
    - `clear` in `INIT` restarts the walk at 0.
- **Reset:** `rst` asserted forces `INIT`, `init_idx` = 0, all outputs 0, and invalidates the update pipeline register. The array contents are not reset directly; the `INIT` walk overwrites them. Reset mid-walk or mid-update discards all in-flight work.
- **Lookup:**
  - In `RUN`, `lookup_valid` at edge n gives `pred_valid` = 1 and `pred_taken` = MSB of the entry during cycle n+1.
  - In `INIT`, a lookup still responds with `pred_valid` = 1 and `pred_taken` = 0, so fetch never stalls on the predictor.
- **Update pipeline (single stage U1):**
  - **Capture:** edge n registers index and direction when `upd_valid` is high and the state is `RUN`. Updates arriving during `INIT` are dropped silently.
  - **Compute:** during cycle n+1, `sat_updn_cp4` computes from the current array value with `up` = `upd_taken` and `dn` = !`upd_taken`.
  - **Write:** at edge n+1 the result is written back.
  - **Saturation:** 2'b11 plus taken stays 2'b11; 2'b00 plus not-taken stays 2'b00.
- **Back-to-back updates:** updates to the same index on consecutive cycles both take effect (net ±2, saturating). The second update reads the array after the first has been written, so no forwarding path is needed.
- **Lookup/write collision:** a lookup sampled at the same edge as a U1 write to the same index returns the pre-write value (read-before-write).
- **`clear` with a pending U1 write:** `clear` sampled at the same edge as a U1 write squashes that write, and `INIT` wins.

## Timing

- **Reset values:** `ready` = 0, `pred_valid` = 0, `pred_taken` = 0, state `INIT`, `init_idx` = 0, U1 valid = 0.
- **Initialisation length:** exactly 2^IDX_BITS cycles (32 at defaults). `ready` rises in the cycle after the edge that writes the last entry.
- **Lookup latency:** 1 cycle, fully pipelined, one lookup per cycle.
- **`pred_valid`:** equals `lookup_valid` delayed one cycle. It is 0 in the cycle after any edge where `lookup_valid` = 0.
- **Update visibility:** an update captured at edge n is visible to a lookup sampled at edge n+2 or later.
- **`ready`:** deasserts in the cycle after `clear` is sampled.

## Structure

- **Shared package `bp_pkg_cp4`:** `CNT_WIDTH`, `IDX_BITS`, `INIT_VAL`, the FSM state encoding (`ST_INIT`, `ST_RUN`), and the index-extraction function.
- **Counter array:** behavioural register array of 2^IDX_BITS × CNT_WIDTH, async-read compatible.
- **Sub-module:** one instance of `sat_updn_cp4` (`WIDTH` = `CNT_WIDTH`) in the U1 write path. No other sub-modules.

## Test plan

- **Reset and init:** assert `rst` for 3 cycles, then release. `ready` stays 0 for 32 cycles, then goes to 1. A lookup of any PC afterwards returns `pred_taken` = 0.
- **Training to taken:** update PC 0x40 with taken twice on consecutive cycles (01→10→11). A lookup at 0x40 two cycles after the last update returns `pred_taken` = 1. A third taken update keeps the counter at 11; verify via two not-taken updates giving `pred_taken` = 0.
- **Saturate low and alias:** four not-taken updates to 0x80 leave the counter at 00. A taken update to 0x80 + 0x80 (= 0x100, same index at IDX_BITS = 5) moves it to 01, and a lookup at 0x80 returns 0.
- **Collision:** an update to 0x44 (counter 01, taken) is captured at edge n, and a lookup of 0x44 is sampled at edge n+1. The lookup returns 0, and a lookup at edge n+2 returns 1.
- **`clear` mid-run:** after training 0x40 to 11, pulse `clear` together with a pending update. `ready` drops for 32 cycles, the squashed update has no effect, and a lookup at 0x40 afterwards returns 0. Updates issued during `INIT` are ignored.
- **Async reset mid-init:** assert `rst` at `init_idx` = 10. All outputs go to 0 immediately. After release, the walk restarts at 0 and `ready` rises after a full 32 cycles.
